// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch sequencer. Owns the program counter, issues one
//   instruction-memory request at a time, and parks the returned word in a
//   single-entry output buffer for the decode stage. A redirect reloads the
//   PC (word-aligned) and squashes any fetch already in flight.
//
// Ports
//   CLK, RST          clock (rising edge) / asynchronous active-high reset
//   Redirect          load PC from Redirect_addr, squash in-flight work
//   Redirect_addr     new PC; low two bits cleared on load
//   Stall             withholds new memory requests while high
//   Mem_req_valid     fetch request valid (combinational, can be withdrawn)
//   Mem_req_addr      fetch address, always the current PC
//   Mem_req_ready     memory accepts request on valid & ready
//   Mem_resp_valid    single-cycle response strobe
//   Mem_resp_data     fetched instruction word
//   Inst_valid        output buffer holds an instruction
//   Inst_out          buffered instruction
//   Inst_pc           address of Inst_out
//   Inst_ready        decode consumes the buffer on Inst_valid & Inst_ready
// ----------------------------------------------------------------------------
module if_fetch_unit #(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       DATA_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
   parameter int unsigned       INC        = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Redirect,
   input  logic [ADDR_W-1:0] Redirect_addr,
   input  logic              Stall,
   output logic              Mem_req_valid,
   output logic [ADDR_W-1:0] Mem_req_addr,
   input  logic              Mem_req_ready,
   input  logic              Mem_resp_valid,
   input  logic [DATA_W-1:0] Mem_resp_data,
   output logic              Inst_valid,
   output logic [DATA_W-1:0] Inst_out,
   output logic [ADDR_W-1:0] Inst_pc,
   input  logic              Inst_ready
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] req_pc_q;
   logic              squash_q;
   logic              inst_valid_q;
   logic [DATA_W-1:0] inst_out_q;
   logic [ADDR_W-1:0] inst_pc_q;

   logic              req_fire;
   logic [ADDR_W-1:0] redir_pc_d;
   logic [ADDR_W-1:0] seq_pc_d;

   // Redirect targets are word aligned; the low bits are intentionally dropped.
   logic              unused_redir_lsbs;
   assign unused_redir_lsbs = ^Redirect_addr[1:0];

   assign redir_pc_d = {Redirect_addr[ADDR_W-1:2], 2'b00};
   // Sequential PC wraps naturally modulo 2^ADDR_W.
   assign seq_pc_d   = req_pc_q + ADDR_W'(INC);

   // Stall can pull back a request the memory has not yet accepted.
   assign Mem_req_valid = (state_q == S_REQ) && !Stall;
   assign Mem_req_addr  = pc_q;
   assign req_fire      = Mem_req_valid && Mem_req_ready;

   assign Inst_valid = inst_valid_q;
   assign Inst_out   = inst_out_q;
   assign Inst_pc    = inst_pc_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_ADDR;
         req_pc_q     <= '0;
         squash_q     <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_out_q   <= '0;
         inst_pc_q    <= '0;
      end else if (Redirect) begin
         // Redirect wins over every normal transition this cycle.
         pc_q         <= redir_pc_d;
         inst_valid_q <= 1'b0;
         case (state_q)
            S_IDLE, S_HOLD: state_q <= S_REQ;
            S_REQ: begin
               if (req_fire) begin
                  // The old-address request is already with memory; its
                  // response must be thrown away when it returns.
                  req_pc_q <= pc_q;
                  squash_q <= 1'b1;
                  state_q  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (Mem_resp_valid) begin
                  // Response lands in the redirect cycle: drop it now, so
                  // there is nothing left to squash.
                  squash_q <= 1'b0;
                  state_q  <= S_REQ;
               end else begin
                  squash_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end else begin
         case (state_q)
            S_IDLE: state_q <= S_REQ;
            S_REQ: begin
               if (req_fire) begin
                  req_pc_q <= pc_q;
                  state_q  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (Mem_resp_valid) begin
                  if (squash_q) begin
                     squash_q <= 1'b0;
                     state_q  <= S_REQ;
                  end else begin
                     inst_out_q   <= Mem_resp_data;
                     inst_pc_q    <= req_pc_q;
                     inst_valid_q <= 1'b1;
                     pc_q         <= seq_pc_d;
                     state_q      <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (inst_valid_q && Inst_ready) begin
                  inst_valid_q <= 1'b0;
                  state_q      <= S_REQ;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Main DUT (RESET_ADDR = 0)
   logic          RST, Redirect, Stall, Mem_req_ready, Mem_resp_valid, Inst_ready;
   logic [AW-1:0] Redirect_addr;
   logic [DW-1:0] Mem_resp_data;
   logic          Mem_req_valid, Inst_valid;
   logic [AW-1:0] Mem_req_addr, Inst_pc;
   logic [DW-1:0] Inst_out;

   // Second DUT (RESET_ADDR near the top of the address space)
   logic          w_rst, w_redirect, w_stall, w_req_ready, w_resp_valid, w_inst_ready;
   logic [AW-1:0] w_redirect_addr;
   logic [DW-1:0] w_resp_data;
   logic          w_req_valid, w_inst_valid;
   logic [AW-1:0] w_req_addr, w_inst_pc;
   logic [DW-1:0] w_inst_out;

   if_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_ADDR(32'h0), .INC(4)) dut (
      .CLK(CLK), .RST(RST), .Redirect(Redirect), .Redirect_addr(Redirect_addr),
      .Stall(Stall), .Mem_req_valid(Mem_req_valid), .Mem_req_addr(Mem_req_addr),
      .Mem_req_ready(Mem_req_ready), .Mem_resp_valid(Mem_resp_valid),
      .Mem_resp_data(Mem_resp_data), .Inst_valid(Inst_valid), .Inst_out(Inst_out),
      .Inst_pc(Inst_pc), .Inst_ready(Inst_ready));

   if_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_ADDR(32'hFFFF_FFFC), .INC(4)) dut_wrap (
      .CLK(CLK), .RST(w_rst), .Redirect(w_redirect), .Redirect_addr(w_redirect_addr),
      .Stall(w_stall), .Mem_req_valid(w_req_valid), .Mem_req_addr(w_req_addr),
      .Mem_req_ready(w_req_ready), .Mem_resp_valid(w_resp_valid),
      .Mem_resp_data(w_resp_data), .Inst_valid(w_inst_valid), .Inst_out(w_inst_out),
      .Inst_pc(w_inst_pc), .Inst_ready(w_inst_ready));

   int n_assert = 0;
   int n_fail   = 0;

   // Scoreboards: expected request addresses and expected {pc, data} words.
   logic [AW-1:0]    req_q[$];
   logic [63:0]      inst_q[$];
   int               hs_q[$];

   // Memory model state
   int               cyc      = 0;
   int               mem_lat  = 1;
   int               pending  = 0;
   logic [AW-1:0]    pend_addr = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic exp_inst(input logic [AW-1:0] pc);
      inst_q.push_back({pc, pc ^ 32'hA5A5_0000});
   endtask

   // One clock cycle: sample handshakes away from the edge, clock, then let the
   // memory model present its response for the new cycle.
   task automatic step();
      logic [AW-1:0] ea;
      logic [63:0]   ei;
      #1;
      if (Mem_req_valid && Mem_req_ready) begin
         ea = (req_q.size() != 0) ? req_q.pop_front() : 'x;
         chk("req_addr", {32'h0, Mem_req_addr}, {32'h0, ea});
         hs_q.push_back(cyc);
         pending   = mem_lat;
         pend_addr = Mem_req_addr;
      end
      if (Inst_valid && Inst_ready) begin
         ei = (inst_q.size() != 0) ? inst_q.pop_front() : 'x;
         chk("inst_pc", {32'h0, Inst_pc}, {32'h0, ei[63:32]});
         chk("inst_out", {32'h0, Inst_out}, {32'h0, ei[31:0]});
      end
      @(posedge CLK);
      cyc++;
      #1;
      Mem_resp_valid = 1'b0;
      if (pending > 0) begin
         pending--;
         if (pending == 0) begin
            Mem_resp_valid = 1'b1;
            Mem_resp_data  = pend_addr ^ 32'hA5A5_0000;
         end
      end
      @(negedge CLK);
   endtask

   task automatic drain(input string tag, input int max);
      int n;
      n = 0;
      while ((inst_q.size() != 0 || req_q.size() != 0) && n < max) begin
         step();
         n++;
      end
      chk(tag, 64'(inst_q.size() + req_q.size()), 64'd0);
   endtask

   initial begin
      int n;
      RST = 1'b1; Redirect = 1'b0; Redirect_addr = '0; Stall = 1'b0;
      Mem_req_ready = 1'b0; Mem_resp_valid = 1'b0; Mem_resp_data = '0; Inst_ready = 1'b0;
      w_rst = 1'b1; w_redirect = 1'b0; w_redirect_addr = '0; w_stall = 1'b0;
      w_req_ready = 1'b0; w_resp_valid = 1'b0; w_resp_data = '0; w_inst_ready = 1'b0;

      @(negedge CLK);
      step();
      chk("rst_req_valid", Mem_req_valid, 0);
      chk("rst_req_addr", Mem_req_addr, 32'h0);
      chk("rst_inst_valid", Inst_valid, 0);
      chk("rst_inst_out", Inst_out, 32'h0);
      chk("rst_inst_pc", Inst_pc, 32'h0);

      // Streaming fetch: 0, 4, 8 one every three cycles
      RST = 1'b0; Mem_req_ready = 1'b1; Inst_ready = 1'b1; mem_lat = 1;
      req_q.push_back(32'h0); req_q.push_back(32'h4); req_q.push_back(32'h8);
      exp_inst(32'h0); exp_inst(32'h4); exp_inst(32'h8);
      hs_q.delete();
      step();
      chk("first_req_valid", Mem_req_valid, 1);
      chk("first_req_addr", Mem_req_addr, 32'h0);
      drain("stream_drain", 40);
      Mem_req_ready = 1'b0;
      chk("stream_hs_count", 64'(hs_q.size()), 64'd3);
      if (hs_q.size() >= 3) begin
         chk("stream_gap1", 64'(hs_q[1] - hs_q[0]), 64'd3);
         chk("stream_gap2", 64'(hs_q[2] - hs_q[1]), 64'd3);
      end

      // Decode back-pressure: buffer held for 5 cycles, no new request
      RST = 1'b1; step(); RST = 1'b0;
      req_q.push_back(32'h0); exp_inst(32'h0);
      Inst_ready = 1'b0; Mem_req_ready = 1'b1;
      n = 0;
      while (!Inst_valid && n < 20) begin step(); n++; end
      chk("bp_inst_arrives", Inst_valid, 1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_inst_valid", Inst_valid, 1);
         chk("bp_inst_out", Inst_out, 32'hA5A5_0000);
         chk("bp_req_valid", Mem_req_valid, 0);
         step();
      end
      Inst_ready = 1'b1;
      req_q.push_back(32'h4);
      step();
      chk("bp_req4_valid", Mem_req_valid, 1);
      chk("bp_req4_addr", Mem_req_addr, 32'h4);
      exp_inst(32'h4);
      drain("bp_drain", 20);

      // Redirect while waiting on the response for 8
      req_q.push_back(32'h8); mem_lat = 2;
      drain("redir_wait_hs", 10);
      Redirect = 1'b1; Redirect_addr = 32'h0000_0103;
      step();
      Redirect = 1'b0;
      chk("redir_wait_ivalid0", Inst_valid, 0);
      step();
      chk("redir_wait_ivalid1", Inst_valid, 0);
      chk("redir_wait_req_valid", Mem_req_valid, 1);
      chk("redir_wait_req_addr", Mem_req_addr, 32'h100);
      mem_lat = 1;
      req_q.push_back(32'h100); exp_inst(32'h100);
      drain("redir_wait_drain", 20);
      Mem_req_ready = 1'b0;

      // Redirect coinciding with a request handshake
      req_q.push_back(32'h104);
      Mem_req_ready = 1'b1; Redirect = 1'b1; Redirect_addr = 32'h200;
      step();
      Redirect = 1'b0;
      step();
      chk("redir_hs_ivalid", Inst_valid, 0);
      chk("redir_hs_req_valid", Mem_req_valid, 1);
      chk("redir_hs_req_addr", Mem_req_addr, 32'h200);
      req_q.push_back(32'h200); exp_inst(32'h200);
      drain("redir_hs_drain", 20);

      // Redirect coinciding with the response in WAIT
      req_q.push_back(32'h204);
      step();
      Redirect = 1'b1; Redirect_addr = 32'h300;
      step();
      Redirect = 1'b0; Mem_req_ready = 1'b0;
      chk("redir_resp_ivalid", Inst_valid, 0);
      chk("redir_resp_req_valid", Mem_req_valid, 1);
      chk("redir_resp_req_addr", Mem_req_addr, 32'h300);

      // Reset during WAIT; late response must be ignored
      req_q.push_back(32'h300); Mem_req_ready = 1'b1; mem_lat = 3;
      step();
      Mem_req_ready = 1'b0; RST = 1'b1;
      #1;
      chk("async_rst_req_valid", Mem_req_valid, 0);
      chk("async_rst_req_addr", Mem_req_addr, 32'h0);
      chk("async_rst_ivalid", Inst_valid, 0);
      step();
      RST = 1'b0;
      step();
      step();
      chk("late_resp_ivalid", Inst_valid, 0);
      chk("late_resp_req_valid", Mem_req_valid, 1);
      chk("late_resp_req_addr", Mem_req_addr, 32'h0);
      mem_lat = 1;
      req_q.push_back(32'h0); exp_inst(32'h0);
      Mem_req_ready = 1'b1;
      drain("restart_drain", 20);
      Mem_req_ready = 1'b0;

      // PC wrap and Stall on the second instance
      w_rst = 1'b0; w_inst_ready = 1'b1;
      @(negedge CLK);
      chk("wrap_req_valid0", w_req_valid, 1);
      chk("wrap_req_addr0", w_req_addr, 32'hFFFF_FFFC);
      w_req_ready = 1'b1;
      @(negedge CLK);
      chk("wrap_wait_valid", w_req_valid, 0);
      w_req_ready = 1'b0; w_resp_valid = 1'b1; w_resp_data = 32'h1234_5678;
      @(negedge CLK);
      w_resp_valid = 1'b0;
      chk("wrap_inst_valid", w_inst_valid, 1);
      chk("wrap_inst_pc", w_inst_pc, 32'hFFFF_FFFC);
      chk("wrap_inst_out", w_inst_out, 32'h1234_5678);
      @(negedge CLK);
      chk("wrap_req_valid1", w_req_valid, 1);
      chk("wrap_req_addr1", w_req_addr, 32'h0);
      w_stall = 1'b1; w_req_ready = 1'b1;
      #1;
      chk("stall_withdraw", w_req_valid, 0);
      @(negedge CLK);
      @(negedge CLK);
      chk("stall_hold_valid", w_req_valid, 0);
      chk("stall_hold_addr", w_req_addr, 32'h0);
      w_stall = 1'b0;
      #1;
      chk("stall_resume_valid", w_req_valid, 1);
      chk("stall_resume_addr", w_req_addr, 32'h0);
      @(negedge CLK);
      chk("stall_resume_accepted", w_req_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch sequencer that owns the program counter and drives instruction memory requests.
- Issues one outstanding fetch at a time and buffers the returned word in a 1-entry output register for decode.
- Advances the PC by INC; on a redirect (branch/jump) it reloads the PC and squashes any in-flight fetch.
- Sits between the branch/jump logic and instruction memory on one side and the decode stage on the other.

Parameters:
ADDR_W, 32, address/PC width
DATA_W, 32, instruction word width
RESET_ADDR, 0, PC value after reset
INC, 4, sequential PC increment in bytes

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  asynchronous active-high reset
Redirect  input  1  load PC from Redirect_addr, squash in-flight work
Redirect_addr  input  ADDR_W  new PC; bits [1:0] forced to 0 on load
Stall  input  1  withholds new memory requests while high
Mem_req_valid  output  1  fetch request valid
Mem_req_addr  output  ADDR_W  fetch address (current PC)
Mem_req_ready  input  1  memory accepts request when valid&ready
Mem_resp_valid  input  1  response word present (1-cycle pulse)
Mem_resp_data  input  DATA_W  fetched instruction
Inst_valid  output  1  output buffer holds an instruction
Inst_out  output  DATA_W  buffered instruction
Inst_pc  output  ADDR_W  address of Inst_out
Inst_ready  input  1  decode consumes buffer when Inst_valid&Inst_ready

Behaviour:
- Clock is CLK. Reset is RST: one clock, asynchronous, active-high.
- Reset values (applied immediately on RST high):
  - state=IDLE, pc=RESET_ADDR, req_pc=0, squash=0.
  - Mem_req_valid=0, Mem_req_addr=RESET_ADDR.
  - Inst_valid=0, Inst_out=0, Inst_pc=0.
- Mem_req_addr = pc at all times.
- Mem_req_valid = (state==REQ) && !Stall. It is combinational; Stall may withdraw an unaccepted request.
- States:
  - IDLE: always -> REQ on the next edge. The first request is visible 1 cycle after RST deasserts.
  - REQ: on Mem_req_valid&Mem_req_ready -> req_pc<=pc, -> WAIT. Otherwise stay in REQ.
  - WAIT: on Mem_resp_valid:
    - squash=1: drop the word, squash<=0, -> REQ.
    - squash=0: Inst_out<=Mem_resp_data, Inst_pc<=req_pc, Inst_valid<=1, pc<=req_pc+INC, -> HOLD.
  - HOLD: on Inst_valid&Inst_ready -> Inst_valid<=0, -> REQ.
- Latency: response to Inst_valid is 1 cycle. Peak throughput is 1 instruction per 3 cycles with single-cycle memory and Inst_ready=1.
- Redirect has highest priority and overrides the transitions above in the same cycle:
  - pc<={Redirect_addr[ADDR_W-1:2],2'b00}; Inst_valid<=0.
  - IDLE or HOLD: -> REQ.
  - REQ without handshake: stay in REQ; the new address appears next cycle.
  - REQ with handshake in the same cycle: -> WAIT, squash<=1. The accepted request is squashed.
  - WAIT: stay in WAIT, squash<=1. If Mem_resp_valid is in the same cycle, that word is dropped, squash stays 0, -> REQ.
- PC arithmetic wraps modulo 2^ADDR_W; INC is added unsigned.
- Mem_resp_valid outside WAIT is ignored with no state change.
- Inst_ready without Inst_valid has no effect.
- Stall has no effect in WAIT or HOLD. Responses and the output buffer drain normally while Stall is high.
- RST asserted mid-operation aborts everything. The outstanding response after reset is ignored because the state is not WAIT.

Test Plan:
- Reset, release RST, Mem_req_ready=1, 1-cycle memory returning addr^32'hA5A5_0000, Inst_ready=1 -> requests at 0,4,8. Inst_pc/Inst_out show 0/A5A5_0000, 4/A5A5_0004, 8/A5A5_0008, one every 3 cycles.
- Inst_ready=0 for 5 cycles after first instruction -> Inst_valid held, Inst_out stable, Mem_req_valid=0 throughout. Request to 4 issues the cycle after Inst_ready=1.
- Redirect=1, Redirect_addr=32'h0000_0103 while in WAIT for addr 8 -> response for 8 dropped, Inst_valid stays 0. Next request at 32'h100, then Inst_pc=32'h100.
- Redirect in the same cycle as a REQ handshake -> that response is dropped, and the next fetch is from the redirect address. Redirect coinciding with Mem_resp_valid in WAIT -> word dropped, REQ next cycle.
- RESET_ADDR=32'hFFFF_FFFC -> second request addr=0 (wrap). Stall=1 during REQ -> Mem_req_valid=0, pc unchanged. Stall=0 -> request resumes at the same address.
- Assert RST during WAIT, then Mem_resp_valid arrives after release -> ignored, Inst_valid=0. Fetch restarts at RESET_ADDR.
